// File: rtl/mem_arbiter.sv
// Arbitrates one single-word RAM port between an 8-word icache refill port and a data port.
// Define MEM_ARB_DPRIO_EN to give the data port fixed priority on simultaneous requests (default: round-robin).
//
// state     | meaning
// IDLE      | sample i_stb/d_stb, grant one
// I_FETCH   | read BURST_LEN words from RAM into the line buffer
// I_DELIVER | stream the line buffer to the icache, one word per cycle
// I_DONE    | one dead cycle while the icache clears its miss state
// D_ACCESS  | single data read/write on the RAM port
// D_DONE    | one-cycle d_ack pulse
module mem_arbiter #(
    parameter int BURST_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stb,
    input  logic [21:0] i_addr,
    output logic [31:0] i_dout,
    output logic        i_ack,
    input  logic        d_stb,
    input  logic        d_we,
    input  logic [21:0] d_addr,
    input  logic [31:0] d_din,
    output logic [31:0] d_dout,
    output logic        d_ack,
    output logic        ram_stb,
    output logic        ram_we,
    output logic [21:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    input  logic        ram_ack
);
    localparam int CW = $clog2(BURST_LEN);
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        I_FETCH,
        I_DELIVER,
        I_DONE,
        D_ACCESS,
        D_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   line_buf [BURST_LEN];
    logic [31:0]   d_dout_r;
    logic          grant_i, grant_d;
    logic          unused_i_addr;

    // Refills always start at word 0, so the word-offset bits of i_addr are not used.
    assign unused_i_addr = ^i_addr[CW-1:0];

`ifdef MEM_ARB_DPRIO_EN
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (d_stb) begin
            grant_d = 1'b1;
        end else if (i_stb) begin
            grant_i = 1'b1;
        end
    end
`else
    logic last_grant;   // 1 = data port was granted last

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_stb && d_stb) begin
            if (last_grant) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_i = i_stb;
            grant_d = d_stb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && (grant_i || grant_d)) begin
            last_grant <= grant_d;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt = I_FETCH;
                    cnt_nxt   = '0;
                end else if (grant_d) begin
                    state_nxt = D_ACCESS;
                end
            end
            I_FETCH: begin
                if (ram_ack) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = I_DELIVER;
                    end
                end
            end
            I_DELIVER: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = I_DONE;
                end
            end
            I_DONE:   state_nxt = IDLE;
            D_ACCESS: begin
                if (ram_ack) begin
                    state_nxt = D_DONE;
                end
            end
            D_DONE:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            d_dout_r <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == D_ACCESS && ram_ack) begin
                d_dout_r <= ram_dout;
            end
        end
    end

    // Line buffer needs no reset: every word is rewritten before it is delivered.
    always_ff @(posedge clk) begin
        if (state == I_FETCH && ram_ack) begin
            line_buf[cnt] <= ram_dout;
        end
    end

    always_comb begin
        ram_stb  = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            I_FETCH: begin
                ram_stb  = 1'b1;
                ram_addr = {i_addr[21:CW], cnt};
            end
            D_ACCESS: begin
                ram_stb  = 1'b1;
                ram_we   = d_we;
                ram_addr = d_addr;
                ram_din  = d_din;
            end
            default: ;
        endcase
    end

    assign i_ack  = (state == I_DELIVER);
    assign i_dout = (state == I_DELIVER) ? line_buf[cnt] : '0;
    assign d_ack  = (state == D_DONE);
    assign d_dout = d_dout_r;

endmodule
